// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the systolic-array operand path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEFAULT_LENGTH      default elements per vector (array edge)
//   DEFAULT_DATA_WIDTH  default bits per element
//   VEC_W               default vector width, DEFAULT_LENGTH*DEFAULT_DATA_WIDTH
//   clog2()             pointer width for a given depth, never less than 1
package systolic_pkg;

  localparam int DEFAULT_LENGTH     = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int VEC_W              = DEFAULT_LENGTH * DEFAULT_DATA_WIDTH;

  // Address width needed to index 'value' entries. A depth of 1 still gets
  // a one-bit pointer so port widths never collapse to zero.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One bank of the ping-pong store: DEPTH x WIDTH register file.
// Latency: write lands on the next clock edge; read is combinational by address.
// Backpressure: none; the caller owns all flow control.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset (clears storage)
//   wr_en      write strobe for wr_addr/wr_data
//   wr_addr    write address
//   wr_data    write word
//   rd_addr    read address
//   rd_data    word stored at rd_addr
module pingpong_bank
  import systolic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = VEC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pingpong_buffer.sv
// Double-buffered vector store: the loader fills one bank while the array drains the other.
// Latency: a bank is readable the cycle after its last write; read data is combinational at rd_ptr.
// Backpressure: in_ready drops while the write bank is still full; out_valid drops while the read bank is empty.
//
// Optional feature macro: PINGPONG_REUSE_EN adds the 'reuse' input. When it is
// high on the final read beat the bank is replayed from word 0 instead of released.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    loader handshake; in_data is the word being offered
//   out_valid/out_ready  array handshake on bank[flag]
//   out_0, out_1         bank 0 / bank 1 word at the current read pointer
//   flag                 bank currently being drained (mux select downstream)
//   reuse                (PINGPONG_REUSE_EN only) replay the read bank instead of releasing it
module pingpong_buffer
  import systolic_pkg::*;
#(
  parameter int LENGTH     = DEFAULT_LENGTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LENGTH*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef PINGPONG_REUSE_EN
  input  logic                         reuse,
`endif
  output logic [LENGTH*DATA_WIDTH-1:0] out_0,
  output logic [LENGTH*DATA_WIDTH-1:0] out_1,
  output logic                         flag
);

  localparam int W     = LENGTH * DATA_WIDTH;
  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic             wr_bank;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic wr_beat;
  logic rd_beat;
  logic wr_done;
  logic rd_last_beat;
  logic hold_bank;
  logic rd_release;

`ifdef PINGPONG_REUSE_EN
  assign hold_bank = reuse;
`else
  assign hold_bank = 1'b0;
`endif

  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[flag];

  assign wr_beat      = in_valid & in_ready;
  assign rd_beat      = out_valid & out_ready;
  assign wr_done      = wr_beat & (wr_ptr == LAST);
  assign rd_last_beat = rd_beat & (rd_ptr == LAST);
  assign rd_release   = rd_last_beat & ~hold_bank;

  // Write completion and read release can land in the same cycle. They never
  // collide: the bank being written is by construction not full, so it cannot
  // be the bank being released.
  always_comb begin
    full_nxt = full;
    if (wr_done) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (rd_release) begin
      full_nxt[flag] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full    <= 2'b00;
      flag    <= 1'b0;
    end else begin
      if (wr_beat) begin
        if (wr_done) begin
          wr_ptr  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (rd_beat) begin
        if (rd_last_beat) begin
          rd_ptr <= '0;
          // A held bank replays from word 0 with flag unchanged.
          if (!hold_bank) begin
            flag <= ~flag;
          end
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      full <= full_nxt;
    end
  end

  pingpong_bank #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_beat & ~wr_bank),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_0)
  );

  pingpong_bank #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_beat & wr_bank),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_1)
  );

endmodule

// File: tb/tb_pingpong_buffer.sv
// Self-checking bench for pingpong_buffer (LENGTH=2, DATA_WIDTH=16, DEPTH=2).
// A bank-level model tracks completed fills and releases as counts; every
// negedge the outputs are compared against it, plus literal directed checks.
module tb_pingpong_buffer;

  localparam int LENGTH     = 2;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 2;
  localparam int W          = LENGTH * DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_0;
  logic [W-1:0] out_1;
  logic         flag;
`ifdef PINGPONG_REUSE_EN
  logic         reuse;
`endif

  always #5 clk = ~clk;

  pingpong_buffer #(
    .LENGTH     (LENGTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PINGPONG_REUSE_EN
    .reuse     (reuse),
`endif
    .out_0     (out_0),
    .out_1     (out_1),
    .flag      (flag)
  );

  int checks = 0;
  int errors = 0;

  // Model: banks are filled alternately 0,1,0,... and released in the same
  // order, so the counts of completed fills/releases determine everything.
  int           fills;
  int           releases;
  int           wr_cnt;
  int           rd_idx;
  logic [W-1:0] mem [2][DEPTH];
  bit           cmp_en = 1'b0;

  function automatic bit m_in_ready();
    return (fills - releases) < 2;
  endfunction

  function automatic bit m_out_valid();
    return (fills - releases) > 0;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fills    = 0;
    releases = 0;
    wr_cnt   = 0;
    rd_idx   = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++)
        mem[b][i] = '0;
  endtask

  task automatic model_apply(input bit iv, input logic [W-1:0] d, input bit ordy, input bit ru);
    bit wb;
    bit rb;
    wb = iv && m_in_ready();
    rb = ordy && m_out_valid();
    if (wb) begin
      mem[fills % 2][wr_cnt] = d;
      wr_cnt++;
      if (wr_cnt == DEPTH) begin
        wr_cnt = 0;
        fills++;
      end
    end
    if (rb) begin
      rd_idx++;
      if (rd_idx == DEPTH) begin
        rd_idx = 0;
        if (!ru) releases++;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic cyc(input bit iv, input logic [W-1:0] d, input bit ordy, input bit ru);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
`ifdef PINGPONG_REUSE_EN
    reuse     = ru;
`endif
    @(posedge clk);
    #1;
    model_apply(iv, d, ordy, ru);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready",  {31'b0, in_ready},  {31'b0, m_in_ready()});
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_out_valid()});
      chk("m_flag",      {31'b0, flag},      W'(releases % 2));
      chk("m_out_0",     out_0,              mem[0][rd_idx]);
      chk("m_out_1",     out_1,              mem[1][rd_idx]);
    end
  end

  initial begin
    bit           iv_r;
    bit           or_r;
    bit           ru_r;
    logic [W-1:0] d_r;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PINGPONG_REUSE_EN
    reuse     = 1'b0;
`endif
    model_reset();
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
    chk("rst_flag",      {31'b0, flag},      32'h0);
    chk("rst_out_0",     out_0,              32'h0);
    chk("rst_out_1",     out_1,              32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill bank 0, then drain it.
    cyc(1'b1, 32'h0001_0002, 1'b0, 1'b0);
    chk("fill1_out_valid", {31'b0, out_valid}, 32'h0);
    cyc(1'b1, 32'h0003_0004, 1'b0, 1'b0);
    chk("fill2_out_valid", {31'b0, out_valid}, 32'h1);
    chk("fill2_flag",      {31'b0, flag},      32'h0);
    chk("fill2_out_0",     out_0,              32'h0001_0002);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain1_out_0",     out_0,              32'h0003_0004);
    chk("drain1_out_valid", {31'b0, out_valid}, 32'h1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain2_flag",      {31'b0, flag},      32'h1);
    chk("drain2_out_valid", {31'b0, out_valid}, 32'h0);

    // Overlap: fill bank 1 while bank 0 drains; last write and release coincide.
    do_reset();
    cyc(1'b1, 32'h0001_0002, 1'b0, 1'b0);
    cyc(1'b1, 32'h0003_0004, 1'b0, 1'b0);
    cyc(1'b1, 32'h0005_0006, 1'b1, 1'b0);
    chk("ovl1_flag",  {31'b0, flag}, 32'h0);
    chk("ovl1_out_0", out_0,         32'h0003_0004);
    cyc(1'b1, 32'h0007_0008, 1'b1, 1'b0);
    chk("ovl2_flag",      {31'b0, flag},      32'h1);
    chk("ovl2_out_valid", {31'b0, out_valid}, 32'h1);
    chk("ovl2_out_1",     out_1,              32'h0005_0006);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ovl3_out_valid", {31'b0, out_valid}, 32'h0);
    chk("ovl3_flag",      {31'b0, flag},      32'h0);

    // Both banks full; writes offered while full must be ignored.
    cyc(1'b1, 32'h0A0A_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h0A0A_0002, 1'b0, 1'b0);
    cyc(1'b1, 32'h0B0B_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h0B0B_0002, 1'b0, 1'b0);
    chk("full_in_ready", {31'b0, in_ready}, 32'h0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("full_rd1_in_ready", {31'b0, in_ready}, 32'h0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("full_rd2_in_ready", {31'b0, in_ready}, 32'h1);
    chk("full_rd2_flag",     {31'b0, flag},     32'h1);
    chk("full_rd2_out_1",    out_1,             32'h0B0B_0001);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a fill.
    do_reset();
    cyc(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    model_reset();
    #2;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("mid_rst_out_0",    out_0,             32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    cyc(1'b1, 32'h3333_3333, 1'b0, 1'b0);
    chk("refill_out_valid", {31'b0, out_valid}, 32'h1);
    chk("refill_flag",      {31'b0, flag},      32'h0);
    chk("refill_out_0",     out_0,              32'h2222_2222);
    cyc(1'b0, '0, 1'b0, 1'b0);

`ifdef PINGPONG_REUSE_EN
    // Replay a bank instead of releasing it.
    do_reset();
    cyc(1'b1, 32'h0001_0002, 1'b0, 1'b0);
    cyc(1'b1, 32'h0003_0004, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("reuse_flag",      {31'b0, flag},      32'h0);
    chk("reuse_out_valid", {31'b0, out_valid}, 32'h1);
    chk("reuse_out_0",     out_0,              32'h0001_0002);
    cyc(1'b0, '0, 1'b0, 1'b0);
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        iv_r = ($urandom_range(0, 9) < 6);
        or_r = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 5 : 8));
        d_r  = $urandom;
        ru_r = 1'b0;
`ifdef PINGPONG_REUSE_EN
        ru_r = ($urandom_range(0, 3) == 0);
`endif
        cyc(iv_r, d_r, or_r, ru_r);
      end
    end

    cyc(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
